// File: rtl/sram_ctrl_if.sv
// LSU-side request/response bundle for sram_ctrl.
// master = pipeline LSU, slave = sram_ctrl.
interface sram_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;

    modport master (output req, we, addr, bmask, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, bmask, wdata, output rdata, ack, busy);
endinterface

// File: rtl/sram_ctrl.sv
// 32-bit LSU to 16-bit async SRAM bridge: each access runs as a low then a high halfword phase.
// Optional one-entry read buffer enabled by defining SRAM_CTRL_RDCACHE_EN.
module sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sram_ctrl_if.slave        lsu,
    output logic [ADDR_W-1:0] o_sram_addr,
    inout  wire  [15:0]       io_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);
    localparam int WORD_W = ADDR_W - 1;
    localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_q;
    logic [3:0]        bmask_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              dq_oe;
    logic [15:0]       dq_out;
    logic              hit;
    logic [31:0]       hit_data;

    wire [WORD_W-1:0] req_word    = lsu.addr[ADDR_W:2];
    wire              phase_last  = (cnt == '0);
    wire              phase_setup = (cnt == CNT_LOAD);
    wire              accept      = (state == IDLE) && lsu.req;
    wire              unused_addr = ^{lsu.addr[31:ADDR_W+1], lsu.addr[1:0]};

`ifdef SRAM_CTRL_RDCACHE_EN
    logic              c_valid;
    logic [WORD_W-1:0] c_tag;
    logic [31:0]       c_data;

    assign hit      = c_valid && (c_tag == req_word);
    assign hit_data = c_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            c_valid <= 1'b0;
            c_tag   <= '0;
            c_data  <= '0;
        end else if (state == RD_HI && phase_last) begin
            c_valid <= 1'b1;
            c_tag   <= word_q;
            c_data  <= {io_sram_dq, rdata_q[15:0]};
        end else if (accept && lsu.we && req_word == c_tag) begin
            c_valid <= 1'b0;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= CNT_LOAD;
        end else begin
            state <= state_nxt;
            // every phase entry restarts the setup+strobe countdown
            if (state_nxt != state)
                cnt <= CNT_LOAD;
            else if (!phase_last)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            word_q  <= '0;
            bmask_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                word_q  <= req_word;
                bmask_q <= lsu.bmask;
                wdata_q <= lsu.wdata;
                if (!lsu.we && hit)
                    rdata_q <= hit_data;
            end
            if (state == RD_LO && phase_last)
                rdata_q[15:0] <= io_sram_dq;
            if (state == RD_HI && phase_last)
                rdata_q[31:16] <= io_sram_dq;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_sram_ce_n = 1'b1;
        o_sram_oe_n = 1'b1;
        o_sram_we_n = 1'b1;
        o_sram_lb_n = 1'b1;
        o_sram_ub_n = 1'b1;
        o_sram_addr = '0;
        dq_oe       = 1'b0;
        dq_out      = '0;
        lsu.ack     = 1'b0;
        lsu.busy    = 1'b0;
        case (state)
            IDLE: begin
                lsu.busy = lsu.req;
                if (lsu.req) begin
                    if (!lsu.we)
                        state_nxt = hit ? DONE : RD_LO;
                    else if (|lsu.bmask[1:0])
                        state_nxt = WR_LO;
                    else if (|lsu.bmask[3:2])
                        state_nxt = WR_HI;
                    else
                        state_nxt = DONE;
                end
            end
            RD_LO, RD_HI: begin
                lsu.busy    = 1'b1;
                o_sram_ce_n = 1'b0;
                o_sram_oe_n = 1'b0;
                o_sram_lb_n = 1'b0;
                o_sram_ub_n = 1'b0;
                o_sram_addr = {word_q, state == RD_HI};
                if (phase_last)
                    state_nxt = (state == RD_LO) ? RD_HI : DONE;
            end
            WR_LO: begin
                lsu.busy    = 1'b1;
                o_sram_ce_n = 1'b0;
                o_sram_we_n = phase_setup;
                o_sram_lb_n = ~bmask_q[0];
                o_sram_ub_n = ~bmask_q[1];
                o_sram_addr = {word_q, 1'b0};
                dq_oe       = 1'b1;
                dq_out      = wdata_q[15:0];
                if (phase_last)
                    state_nxt = (|bmask_q[3:2]) ? WR_HI : DONE;
            end
            WR_HI: begin
                lsu.busy    = 1'b1;
                o_sram_ce_n = 1'b0;
                o_sram_we_n = phase_setup;
                o_sram_lb_n = ~bmask_q[2];
                o_sram_ub_n = ~bmask_q[3];
                o_sram_addr = {word_q, 1'b1};
                dq_oe       = 1'b1;
                dq_out      = wdata_q[31:16];
                if (phase_last)
                    state_nxt = DONE;
            end
            DONE: begin
                lsu.ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign lsu.rdata  = rdata_q;
    assign io_sram_dq = dq_oe ? dq_out : 16'bz;
endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: transaction-level word-memory model with per-cycle bus/handshake
// expectations, an async SRAM model, directed cases and randomized accesses.
module tb_sram_ctrl;
    localparam int ADDR_W = 18;
    localparam int W      = 1;

    logic clk = 1'b0;
    logic rst;
    sram_ctrl_if lsu();
    wire  [15:0]       sram_dq;
    logic [ADDR_W-1:0] sram_addr;
    logic ce_n, oe_n, we_n, lb_n, ub_n;

    sram_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_rst(rst), .lsu(lsu),
        .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
        .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
        .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
    );

    always #5 clk = ~clk;

    logic [15:0] sram_mem  [0:(1<<ADDR_W)-1];
    logic [31:0] ref_words [0:(1<<(ADDR_W-1))-1];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? sram_mem[sram_addr] : 16'bz;

    int vectors = 0, miscompares = 0;
    int cyc = 0, last_ack_cyc = -1, req_cyc = 0, we_pulses = 0, oe_cycles = 0;
    logic prev_we_n = 1'b1;
    logic chk_en = 1'b0;

    logic              exp_ack, exp_busy, exp_rd_chk, exp_phase, exp_is_wr;
    logic [31:0]       exp_rdata;
    logic [ADDR_W-1:0] exp_sram_addr;
    logic [4:0]        exp_ctl;   // {ce_n, oe_n, we_n, lb_n, ub_n}
    logic [15:0]       exp_dq;
`ifdef SRAM_CTRL_RDCACHE_EN
    logic              c_valid;
    logic [16:0]       c_tag;
`endif
    logic [16:0]       pool [0:5];

    function automatic logic [15:0] pat(input int i);
        return 16'((i * 40503) ^ 32'h5A5A);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // async SRAM write model and bus activity counters, sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
        end
        if (!we_n && prev_we_n) we_pulses++;
        prev_we_n = we_n;
        if (!oe_n) oe_cycles++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst && lsu.ack === 1'b1) last_ack_cyc = cyc;
        if (chk_en) begin
            check("ack", 32'(lsu.ack), 32'(exp_ack));
            check("busy", 32'(lsu.busy), 32'(exp_busy));
            if (exp_rd_chk) check("rdata", lsu.rdata, exp_rdata);
            if (exp_phase) begin
                check("sram_addr", 32'(sram_addr), 32'(exp_sram_addr));
                check("sram_ctl", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, {27'b0, exp_ctl});
                if (exp_is_wr) check("dq_drive", {16'b0, sram_dq}, {16'b0, exp_dq});
            end else begin
                check("sram_idle", {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_phase(input logic w, input logic [16:0] word, input logic hi,
                             input int c, input logic [3:0] m, input logic [31:0] d);
        int lbi;
        lbi           = hi ? 2 : 0;
        exp_phase     = 1'b1;
        exp_is_wr     = w;
        exp_rd_chk    = w;
        exp_sram_addr = {word, hi};
        exp_ctl       = {1'b0, w, (w ? (c == 0) : 1'b1), (w ? ~m[lbi] : 1'b0), (w ? ~m[lbi+1] : 1'b0)};
        exp_dq        = hi ? d[31:16] : d[15:0];
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE. The accept edge enters
    // the first phase, each phase lasts 1+W cycles, then one DONE cycle carries the ack.
    task automatic access(input logic w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        logic [16:0] word;
        logic        hit;
        logic        halves [0:1];
        int          nh;
        word = a[18:2];
        hit  = 1'b0;
`ifdef SRAM_CTRL_RDCACHE_EN
        hit = !w && c_valid && (c_tag == word);
`endif
        nh = 0;
        if (!w) begin
            if (!hit) begin halves[0] = 1'b0; halves[1] = 1'b1; nh = 2; end
        end else begin
            if (|m[1:0]) begin halves[nh] = 1'b0; nh++; end
            if (|m[3:2]) begin halves[nh] = 1'b1; nh++; end
        end
        lsu.req = 1'b1; lsu.we = w; lsu.addr = a; lsu.bmask = m; lsu.wdata = d;
        req_cyc  = cyc;
        exp_busy = 1'b1; exp_ack = 1'b0; exp_phase = 1'b0; exp_rd_chk = 1'b1;
        step();
        for (int p = 0; p < nh; p++) begin
            for (int c = 0; c <= W; c++) begin
                set_phase(w, word, halves[p], c, m, d);
                step();
            end
        end
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_words[word][8*b +: 8] = d[8*b +: 8];
`ifdef SRAM_CTRL_RDCACHE_EN
            if (c_tag == word) c_valid = 1'b0;
`endif
        end else begin
            exp_rdata = ref_words[word];
`ifdef SRAM_CTRL_RDCACHE_EN
            c_valid = 1'b1;
            c_tag   = word;
`endif
        end
        lsu.req = 1'b0;
        exp_phase = 1'b0; exp_ack = 1'b1; exp_busy = 1'b0; exp_rd_chk = 1'b1;
        step();
        exp_ack = 1'b0;
    endtask

    task automatic apply_reset(input string tag);
        chk_en  = 1'b0;
        rst     = 1'b1;
        lsu.req = 1'b0;
        #1;
        check({tag, "_ctl"}, {27'b0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        check({tag, "_ack"}, 32'(lsu.ack), 32'h0);
        check({tag, "_busy"}, 32'(lsu.busy), 32'h0);
        check({tag, "_rdata"}, lsu.rdata, 32'h0);
        check({tag, "_addr"}, 32'(sram_addr), 32'h0);
        repeat (2) begin
            @(negedge clk);
            check({tag, "_ack_held"}, 32'(lsu.ack), 32'h0);
        end
        step();
        rst = 1'b0;
`ifdef SRAM_CTRL_RDCACHE_EN
        c_valid = 1'b0;
`endif
        exp_rdata = '0; exp_ack = 1'b0; exp_busy = 1'b0; exp_phase = 1'b0; exp_rd_chk = 1'b1;
        chk_en = 1'b1;
    endtask

    // Read accepted, run through RD_LO, reset lands in the middle of RD_HI.
    task automatic aborted_read(input logic [31:0] a);
        logic [16:0] word;
        word = a[18:2];
        lsu.req = 1'b1; lsu.we = 1'b0; lsu.addr = a; lsu.bmask = 4'hF; lsu.wdata = '0;
        exp_busy = 1'b1; exp_ack = 1'b0;
        step();
        for (int c = 0; c <= W; c++) begin
            set_phase(1'b0, word, 1'b0, c, 4'hF, 32'h0);
            step();
        end
        set_phase(1'b0, word, 1'b1, 0, 4'hF, 32'h0);
        @(negedge clk);
        #1;
        apply_reset("t5_abort");
    endtask

    initial begin
        int p0, o0;
        logic [31:0] a;
        for (int i = 0; i < (1 << ADDR_W); i++) sram_mem[i] = pat(i);
        for (int i = 0; i < (1 << (ADDR_W - 1)); i++) ref_words[i] = {pat(2*i + 1), pat(2*i)};
        pool[0] = 17'h00004; pool[1] = 17'h00005; pool[2] = 17'h1FFFF;
        pool[3] = 17'h00123; pool[4] = 17'h10000; pool[5] = 17'h00000;
        lsu.req = 1'b0; lsu.we = 1'b0; lsu.addr = '0; lsu.bmask = '0; lsu.wdata = '0;
        rst = 1'b0;
        #1;
        apply_reset("t0_power_on");
        repeat (3) step();
        apply_reset("t1_idle_reset");

        // full write then full read of 0x10
        p0 = we_pulses;
        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        check("t2_hw8", {16'b0, sram_mem[8]}, 32'hBEEF);
        check("t2_hw9", {16'b0, sram_mem[9]}, 32'hDEAD);
        check("t2_we_pulses", 32'(we_pulses - p0), 32'd2);
        access(1'b0, 32'h10, 4'h0, 32'h0);
        check("t2_rdata", lsu.rdata, 32'hDEADBEEF);
        check("t2_rd_latency", 32'(last_ack_cyc - (req_cyc + 1)), 32'd4);

        // single high-half byte write
        access(1'b1, 32'h10, 4'b0100, 32'h00AA0000);
        access(1'b0, 32'h10, 4'h0, 32'h0);
        check("t3_rdata", lsu.rdata, 32'hDEAABEEF);

        // empty mask write
        p0 = we_pulses;
        access(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
        check("t4_latency", 32'(last_ack_cyc - req_cyc), 32'd1);
        check("t4_we_pulses", 32'(we_pulses - p0), 32'd0);
        check("t4_hw8", {16'b0, sram_mem[8]}, 32'hBEEF);
        check("t4_hw9", {16'b0, sram_mem[9]}, 32'hDEAA);

        // reset during RD_HI, then re-read
        aborted_read(32'h10);
        access(1'b0, 32'h10, 4'h0, 32'h0);
        check("t5_reread", lsu.rdata, 32'hDEAABEEF);

        // repeated read: buffered when the read buffer is built in
        o0 = oe_cycles;
        access(1'b0, 32'h10, 4'h0, 32'h0);
        check("t6_rdata", lsu.rdata, 32'hDEAABEEF);
`ifdef SRAM_CTRL_RDCACHE_EN
        check("t6_hit_latency", 32'(last_ack_cyc - req_cyc), 32'd1);
        check("t6_hit_oe_cycles", 32'(oe_cycles - o0), 32'd0);
`else
        check("t6_latency", 32'(last_ack_cyc - req_cyc), 32'd5);
        check("t6_oe_cycles", 32'(oe_cycles - o0), 32'd4);
`endif
        access(1'b1, 32'h10, 4'hF, 32'h12345678);
        o0 = oe_cycles;
        access(1'b0, 32'h10, 4'h0, 32'h0);
        check("t6_new_rdata", lsu.rdata, 32'h12345678);
        check("t6_new_latency", 32'(last_ack_cyc - req_cyc), 32'd5);
        check("t6_new_oe_cycles", 32'(oe_cycles - o0), 32'd4);

        // randomized traffic over a small word pool with random ignored address bits
        for (int n = 0; n < 300; n++) begin
            a = ($urandom & 32'hFFF8_0003) | {13'b0, pool[$urandom_range(0, 5)], 2'b00};
            access(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) step();
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
